instr_fetch_stage: RTL and testbench

- Fetch stage directly downstream of the program counter. Takes the current PC and issues one instruction-cache read per PC value.
- Holds the PC (drives its stall input) while a miss is outstanding or decode is back-pressuring. Presents the fetched word plus its PC to decode through the IF/ID register.
- Kills in-flight fetches on branch, jump or panic redirects so no wrong-path instruction reaches decode.

---
 rtl/instr_fetch_stage.sv | 77 +++++++
 tb/tb_instr_fetch_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: issues one I-cache read per PC, feeds IF/ID, and kills wrong-path fetches on redirect.
module instr_fetch_stage #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               redirect,
    input  logic               de_stall,
    output logic               ic_req,
    output logic [ADDR_W-1:0]  ic_addr,
    input  logic               ic_valid,
    input  logic [INSTR_W-1:0] ic_rdata,
    output logic               pc_stall,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               fetch_timeout
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;
    localparam logic [7:0] TO_MAX = 8'(TIMEOUT);

    logic [1:0]         state, state_n;
    logic [ADDR_W-1:0]  fetch_addr, buf_pc;
    logic [INSTR_W-1:0] buf_instr;
    logic [7:0]         wait_cnt;
    logic               busy, advance, room, release_buf, waiting;

    assign busy        = (state == FETCH) | (state == DRAIN);
    assign ic_req      = busy;
    assign ic_addr     = fetch_addr;
    assign advance     = (state == FETCH) & ic_valid & ~redirect;
    assign pc_stall    = ~redirect & ~advance;
    assign room        = ~if_valid | ~de_stall;
    assign release_buf = (state == HOLD) & ~redirect & ~de_stall;
    assign waiting     = busy & ~ic_valid;

    // A killed request still waits in DRAIN for its response so the cache handshake stays paired.
    assign state_n = (state == IDLE)  ? FETCH :
                     (state == FETCH) ? (ic_valid ? ((redirect | room) ? IDLE : HOLD) : (redirect ? DRAIN : FETCH)) :
                     (state == HOLD)  ? ((redirect | ~de_stall) ? IDLE : HOLD) :
                                        (ic_valid ? IDLE : DRAIN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            fetch_addr    <= '0;
            buf_pc        <= '0;
            buf_instr     <= '0;
            if_valid      <= 1'b0;
            if_instr      <= '0;
            if_pc         <= '0;
            wait_cnt      <= '0;
            fetch_timeout <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE) fetch_addr <= pc_in;
            if (advance & ~room) begin
                buf_instr <= ic_rdata;
                buf_pc    <= fetch_addr;
            end
            if (redirect) if_valid <= 1'b0;
            else if ((advance & room) | release_buf) begin
                if_valid <= 1'b1;
                if_instr <= release_buf ? buf_instr : ic_rdata;
                if_pc    <= release_buf ? buf_pc : fetch_addr;
            end else if (!de_stall) if_valid <= 1'b0;
            wait_cnt <= waiting ? ((wait_cnt == TO_MAX) ? wait_cnt : wait_cnt + 8'd1) : 8'd0;
            if (waiting & (wait_cnt + 8'd1 == TO_MAX)) fetch_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: vector table, directed corner sequences and random traffic against a transaction-level model.
module tb_instr_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_in = '0;
    logic        redirect = 1'b0;
    logic        de_stall = 1'b0;
    logic        ic_valid = 1'b0;
    logic [31:0] ic_rdata = '0;
    logic        ic_req, pc_stall, if_valid, fetch_timeout;
    logic [31:0] ic_addr, if_instr, if_pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch_stage #(.ADDR_W(32), .INSTR_W(32), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .redirect(redirect), .de_stall(de_stall),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_rdata(ic_rdata),
        .pc_stall(pc_stall), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .fetch_timeout(fetch_timeout)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } word_t;

    // Model: an outstanding request (possibly killed), a one-deep overflow queue and the IF/ID contents.
    bit          m_req, m_kill, m_ifv, m_to;
    logic [31:0] m_addr, m_ifi, m_ifp;
    int          m_wait;
    word_t       m_buf[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req = 0; m_kill = 0; m_ifv = 0; m_to = 0;
        m_addr = '0; m_ifi = '0; m_ifp = '0; m_wait = 0;
        m_buf.delete();
    endtask

    task automatic model_compare(input string tag);
        chk({tag, ".ic_req"}, ic_req, m_req);
        chk({tag, ".ic_addr"}, ic_addr, m_addr);
        chk({tag, ".pc_stall"}, pc_stall, !(redirect || (m_req && !m_kill && ic_valid)));
        chk({tag, ".if_valid"}, if_valid, m_ifv);
        chk({tag, ".if_instr"}, if_instr, m_ifi);
        chk({tag, ".if_pc"}, if_pc, m_ifp);
        chk({tag, ".fetch_timeout"}, fetch_timeout, m_to);
    endtask

    task automatic model_step();
        bit          idle, ld;
        logic [31:0] li, lp;
        idle = !m_req && m_buf.size() == 0;
        ld = 0; li = '0; lp = '0;
        if (m_req && !ic_valid) begin
            if (m_wait < 255) m_wait++;
            if (m_wait >= 255) m_to = 1;
        end else m_wait = 0;
        if (idle) begin
            m_req = 1; m_kill = 0; m_addr = pc_in;
        end else if (m_req) begin
            if (ic_valid) begin
                m_req = 0;
                if (!m_kill && !redirect) begin
                    if (!m_ifv || !de_stall) begin ld = 1; li = ic_rdata; lp = m_addr; end
                    else m_buf.push_back('{ic_rdata, m_addr});
                end
            end else if (redirect) m_kill = 1;
        end else begin
            if (redirect) m_buf.delete();
            else if (!de_stall) begin
                ld = 1; li = m_buf[0].instr; lp = m_buf[0].pc;
                m_buf.delete();
            end
        end
        if (redirect) m_ifv = 0;
        else if (ld) begin m_ifv = 1; m_ifi = li; m_ifp = lp; end
        else if (!de_stall) m_ifv = 0;
    endtask

    task automatic drive(input bit rd, input bit ds, input bit iv, input logic [31:0] rdat, input logic [31:0] pc);
        redirect = rd; de_stall = ds; ic_valid = iv; ic_rdata = rdat; pc_in = pc;
        #1;
    endtask

    task automatic finish_cycle(input string tag);
        model_compare(tag);
        model_step();
        @(negedge clk);
    endtask

    task automatic step(input string tag, input bit rd, input bit ds, input bit iv, input logic [31:0] rdat, input logic [31:0] pc);
        drive(rd, ds, iv, rdat, pc);
        finish_cycle(tag);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".ic_req"}, ic_req, 0);
        chk({tag, ".ic_addr"}, ic_addr, 0);
        chk({tag, ".pc_stall"}, pc_stall, 1);
        chk({tag, ".if_valid"}, if_valid, 0);
        chk({tag, ".if_instr"}, if_instr, 0);
        chk({tag, ".if_pc"}, if_pc, 0);
        chk({tag, ".fetch_timeout"}, fetch_timeout, 0);
    endtask

    // Asserts reset in the middle of a cycle, checks the cleared outputs, releases at the next falling edge.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2 reset = 1'b0;
        redirect = 0; de_stall = 0; ic_valid = 0;
        #1 chk_reset_outputs(tag);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit          rd, ds, iv;
        logic [31:0] rdat, pc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_stall, e_ifv;
        logic [31:0] e_instr, e_pc;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{0, 0, 0, 32'h0,        32'h0,   0, 32'h0,   1, 0, 32'h0,        32'h0};
        tbl[1]  = '{0, 0, 1, 32'hAAAA0001, 32'h0,   1, 32'h0,   0, 0, 32'h0,        32'h0};
        tbl[2]  = '{0, 1, 0, 32'h0,        32'h4,   0, 32'h0,   1, 1, 32'hAAAA0001, 32'h0};
        tbl[3]  = '{0, 1, 0, 32'h0,        32'h4,   1, 32'h4,   1, 1, 32'hAAAA0001, 32'h0};
        tbl[4]  = '{0, 1, 1, 32'hBBBB0002, 32'h4,   1, 32'h4,   0, 1, 32'hAAAA0001, 32'h0};
        tbl[5]  = '{0, 1, 0, 32'h0,        32'h8,   0, 32'h4,   1, 1, 32'hAAAA0001, 32'h0};
        tbl[6]  = '{0, 0, 0, 32'h0,        32'h8,   0, 32'h4,   1, 1, 32'hAAAA0001, 32'h0};
        tbl[7]  = '{0, 0, 0, 32'h0,        32'h8,   0, 32'h4,   1, 1, 32'hBBBB0002, 32'h4};
        tbl[8]  = '{1, 0, 0, 32'h0,        32'h8,   1, 32'h8,   0, 0, 32'hBBBB0002, 32'h4};
        tbl[9]  = '{0, 0, 0, 32'h0,        32'h100, 1, 32'h8,   1, 0, 32'hBBBB0002, 32'h4};
        tbl[10] = '{0, 0, 1, 32'hDEAD0000, 32'h100, 1, 32'h8,   1, 0, 32'hBBBB0002, 32'h4};
        tbl[11] = '{0, 0, 0, 32'h0,        32'h100, 0, 32'h8,   1, 0, 32'hBBBB0002, 32'h4};
        tbl[12] = '{0, 0, 0, 32'h0,        32'h104, 1, 32'h100, 1, 0, 32'hBBBB0002, 32'h4};

        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rd, tbl[i].ds, tbl[i].iv, tbl[i].rdat, tbl[i].pc);
            chk($sformatf("vec%0d.ic_req", i), ic_req, tbl[i].e_req);
            chk($sformatf("vec%0d.ic_addr", i), ic_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d.pc_stall", i), pc_stall, tbl[i].e_stall);
            chk($sformatf("vec%0d.if_valid", i), if_valid, tbl[i].e_ifv);
            chk($sformatf("vec%0d.if_instr", i), if_instr, tbl[i].e_instr);
            chk($sformatf("vec%0d.if_pc", i), if_pc, tbl[i].e_pc);
            model_step();
            @(negedge clk);
        end

        // Ten-cycle miss on 0x100: request held, PC held, IF/ID untouched.
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 32'h0, 32'h104);
            chk("miss.pc_stall", pc_stall, 1);
            chk("miss.ic_addr", ic_addr, 32'h100);
            chk("miss.if_valid", if_valid, 0);
            finish_cycle("miss");
        end
        step("miss_ret", 0, 0, 1, 32'h1234_5678, 32'h104);
        drive(0, 1, 0, 32'h0, 32'h104);
        chk("miss_ret.if_instr", if_instr, 32'h1234_5678);
        chk("miss_ret.if_pc", if_pc, 32'h100);
        finish_cycle("miss_ret");

        // Redirect three cycles into a miss on 0x40; the late word is dropped, next fetch is 0x100.
        do_reset("rst_a");
        step("redir", 0, 0, 0, 32'h0, 32'h40);
        for (int i = 0; i < 3; i++) step("redir", 0, 0, 0, 32'h0, 32'h40);
        step("redir", 1, 0, 0, 32'h0, 32'h40);
        step("redir", 0, 0, 0, 32'h0, 32'h100);
        step("redir", 0, 0, 1, 32'hBAD0_0BAD, 32'h100);
        step("redir", 0, 0, 0, 32'h0, 32'h100);
        drive(0, 0, 0, 32'h0, 32'h104);
        chk("redir.ic_addr", ic_addr, 32'h100);
        chk("redir.if_valid", if_valid, 0);
        finish_cycle("redir");

        // Cache never answers: flag rises after 255 waiting cycles and is sticky.
        do_reset("rst_b");
        for (int n = 0; n < 300; n++) begin
            drive(0, 0, 0, 32'h0, 32'h200);
            if (n == 255) chk("timeout.before", fetch_timeout, 0);
            if (n == 256) chk("timeout.at", fetch_timeout, 1);
            if (n == 299) chk("timeout.sticky", fetch_timeout, 1);
            finish_cycle("timeout");
        end
        step("timeout_ans", 0, 0, 1, 32'h5555_AAAA, 32'h200);
        step("timeout_ans", 0, 0, 0, 32'h0, 32'h204);
        do_reset("rst_c");

        // Reset mid-FETCH, then a late response lands in IDLE and must be ignored.
        step("late", 0, 0, 0, 32'h0, 32'h300);
        step("late", 0, 0, 0, 32'h0, 32'h300);
        do_reset("rst_d");
        drive(0, 0, 1, 32'hFEED_FACE, 32'h80);
        chk("late.pc_stall", pc_stall, 1);
        finish_cycle("late");
        drive(0, 0, 0, 32'h0, 32'h84);
        chk("late.ic_addr", ic_addr, 32'h80);
        chk("late.if_valid", if_valid, 0);
        finish_cycle("late");
        step("late", 0, 0, 1, 32'h0000_1111, 32'h84);

        // HOLD with decode stalled for five cycles before release.
        step("hold", 0, 1, 0, 32'h0, 32'h84);
        step("hold", 0, 1, 1, 32'h0000_2222, 32'h84);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 32'h0, 32'h88);
            chk("hold.pc_stall", pc_stall, 1);
            chk("hold.if_instr", if_instr, 32'h0000_1111);
            finish_cycle("hold");
        end
        step("hold", 0, 0, 0, 32'h0, 32'h88);
        drive(0, 1, 0, 32'h0, 32'h88);
        chk("hold.rel_instr", if_instr, 32'h0000_2222);
        chk("hold.rel_pc", if_pc, 32'h84);
        finish_cycle("hold");

        for (int i = 0; i < 3000; i++) begin
            bit iv;
            iv = m_req ? ($urandom_range(3) == 0) : ($urandom_range(7) == 0);
            step("rand", $urandom_range(9) == 0, $urandom_range(2) == 0, iv, $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
